// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_if
// Brief    : Memory fetch port and core-facing head port of the prefetch queue.
// Revision : 1.0
// ============================================================================
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_valid;
  logic [CW-1:0]   count;

  modport master (
    output mem_req, mem_addr, inst, inst_pc, inst_valid, count,
    input  mem_ack, mem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  mem_req, mem_addr, inst, inst_pc, inst_valid, count,
    output mem_ack, mem_rdata, redirect, redirect_pc, stall
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Sequential instruction prefetch queue with single-outstanding
//            memory requests, PC tagging and redirect flush.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = 32'h00000013
) (
  input logic          clk,
  input logic          n_rst,
  fetch_queue_if.master bus
);
  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  always_comb begin
    pop        = (count_q != '0) && !bus.stall;
    push       = (state_q == REQ) && bus.mem_ack && !bus.redirect;
    count_next = count_q + CW'(push) - CW'(pop);

    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    count_d    = count_next;

    if (bus.redirect) begin
      // Flush wins over any pop or ack; an unacked request must still be retired.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      case (state_q)
        REQ:     state_d = bus.mem_ack ? IDLE : DROP;
        DROP:    state_d = bus.mem_ack ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (count_next < FULL) begin
            state_d    = REQ;
            mem_addr_d = fetch_pc_q;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            fetch_pc_d = fetch_pc_q + STEP;
            if (count_next < FULL) mem_addr_d = fetch_pc_q + STEP;
            else                   state_d    = IDLE;
          end
        end
        DROP: begin
          if (bus.mem_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.mem_rdata;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.count      = count_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = (count_q != '0) ? data_mem[rd_ptr_q] : NOP;
  assign bus.inst_pc    = (count_q != '0) ? pc_mem[rd_ptr_q]   : '0;
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed scoreboard bench for the instruction prefetch queue.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;
  logic clk;
  logic n_rst;

  int passed = 0;
  int total  = 0;

  logic [31:0] sb_pc[$];
  logic [31:0] sb_inst[$];
  logic [31:0] exp_fetch;
  logic [31:0] drop_addr;
  logic        drop_pending;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

  fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(32'h00000013)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock of normal traffic: memory answers the presented address with addr+0x100.
  task automatic cyc(input logic ack, input logic stl);
    bus.mem_ack   = ack;
    bus.stall     = stl;
    bus.redirect  = 1'b0;
    bus.mem_rdata = bus.mem_addr + 32'h100;
    chk("count", 32'(bus.count), sb_pc.size());
    chk("inst_valid", bus.inst_valid, sb_pc.size() != 0);
    if (bus.mem_req && ack) begin
      if (drop_pending) begin
        chk("drop_addr", bus.mem_addr, drop_addr);
        drop_pending = 1'b0;
      end else begin
        chk("fetch_addr", bus.mem_addr, exp_fetch);
        sb_pc.push_back(exp_fetch);
        sb_inst.push_back(exp_fetch + 32'h100);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (bus.inst_valid && !stl && sb_pc.size() > 0) begin
      chk("inst_pc", bus.inst_pc, sb_pc.pop_front());
      chk("inst", bus.inst, sb_inst.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic redir(input logic [31:0] rpc, input logic ack, input logic stl);
    bus.redirect    = 1'b1;
    bus.redirect_pc = rpc;
    bus.mem_ack     = ack;
    bus.stall       = stl;
    bus.mem_rdata   = bus.mem_addr + 32'h100;
    if (bus.mem_req) begin
      if (ack) drop_pending = 1'b0;
      else if (!drop_pending) begin
        drop_pending = 1'b1;
        drop_addr    = exp_fetch;
      end
    end
    sb_pc.delete();
    sb_inst.delete();
    exp_fetch = rpc;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
  endtask

  task automatic apply_reset();
    bus.mem_ack  = 1'b0;
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst", bus.inst, 32'h00000013);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    sb_pc.delete();
    sb_inst.delete();
    exp_fetch    = 32'h0;
    drop_pending = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("idle_after_reset", bus.mem_req, 1'b0);
    @(posedge clk); #1;
    chk("first_req", bus.mem_req, 1'b1);
    chk("first_addr", bus.mem_addr, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (!bus.inst_valid) break;
      cyc(1'b0, 1'b0);
    end
    chk("drain_valid", bus.inst_valid, 1'b0);
    chk("drain_sb", sb_pc.size(), 32'd0);
  endtask

  initial begin
    n_rst           = 1'b1;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.stall       = 1'b0;
    exp_fetch       = '0;
    drop_addr       = '0;
    drop_pending    = 1'b0;
    #2;
    apply_reset();

    // Streaming: ack held high, one instruction per cycle.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
    drain();

    // Reset pulse with a request outstanding.
    chk("pre_reset_req", bus.mem_req, 1'b1);
    apply_reset();

    // Stall fills the queue, then release resumes fetching at 0x10.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    chk("full_req_low", bus.mem_req, 1'b0);
    chk("full_count", 32'(bus.count), 32'd4);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("full_hold_req", bus.mem_req, 1'b0);
    cyc(1'b1, 1'b0);
    chk("resume_req", bus.mem_req, 1'b1);
    chk("resume_addr", bus.mem_addr, 32'h10);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    drain();

    // Redirect while request at 0x8 is pending; its late ack is discarded.
    apply_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("pre_drop_addr", bus.mem_addr, 32'h8);
    redir(32'h200, 1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("drop_hold_addr", bus.mem_addr, 32'h8);
    chk("drop_req", bus.mem_req, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("after_drop_idle", bus.mem_req, 1'b0);
    cyc(1'b0, 1'b0);
    chk("redir_addr", bus.mem_addr, 32'h200);
    cyc(1'b1, 1'b0);
    drain();

    // Redirect coinciding with an ack while two entries are held.
    apply_reset();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("two_held", 32'(bus.count), 32'd2);
    redir(32'h300, 1'b1, 1'b0);
    chk("redir_ack_count", 32'(bus.count), 32'd0);
    chk("redir_ack_valid", bus.inst_valid, 1'b0);
    chk("redir_ack_idle", bus.mem_req, 1'b0);
    cyc(1'b0, 1'b0);
    chk("redir_ack_addr", bus.mem_addr, 32'h300);

    // Simultaneous push/pop at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    chk("three_held", 32'(bus.count), 32'd3);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0);
      chk("pushpop_count", 32'(bus.count), 32'd3);
    end
    drain();

    // Address wrap at the top of the address space.
    redir(32'hFFFFFFFC, 1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("wrap_addr_hi", bus.mem_addr, 32'hFFFFFFFC);
    cyc(1'b1, 1'b0);
    chk("wrap_addr_lo", bus.mem_addr, 32'h0);
    cyc(1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch queue that sits between instruction memory and the `cpu` core's `inst`/`stall` inputs. It issues sequential word fetches over a single-outstanding req/ack memory port and buffers up to DEPTH returned instructions with their PCs. It presents the head entry to the core, and flushes and restarts fetch on a redirect.

## Interface
- XLEN, 32, instruction/address width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- NOP, 32'h00000013, value driven on `inst` when queue is empty
- `clk`  in  1  clock, rising edge
- `n_rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `mem_req`  out  1  fetch request; held until `mem_ack`
- `mem_addr`  out  XLEN  fetch address; stable while `mem_req` high
- `mem_ack`  in  1  `mem_rdata` valid for current request; ignored when `mem_req` low
- `mem_rdata`  in  XLEN  fetched instruction
- `redirect`  in  1  flush queue, restart fetch at `redirect_pc`
- `redirect_pc`  in  XLEN  new fetch address
- `stall`  in  1  core not consuming this cycle
- `inst`  out  XLEN  head instruction, NOP when empty
- `inst_pc`  out  XLEN  head PC, 0 when empty
- `inst_valid`  out  1  queue non-empty
- `count`  out  $clog2(DEPTH)+1  entries held

## Operation
- FSM states: IDLE (no request), REQ (request outstanding, result kept), DROP (request outstanding, result discarded).
- Registers: `fetch_pc` (next address to request), `mem_addr` register, circular buffer with rd/wr pointers mod DEPTH, `count`.
- IDLE: `mem_req`=0. If `count_next` < DEPTH, load `mem_addr`←`fetch_pc` and go REQ.
- REQ: `mem_req`=1. On `mem_ack`: push {`fetch_pc`, `mem_rdata`}, `fetch_pc`+=4 (mod 2^XLEN). Stay REQ with `mem_addr`←`fetch_pc`+4 if post-push/pop count < DEPTH, else IDLE.
- DROP: `mem_req`=1, `mem_addr` holds the abandoned address. On `mem_ack`: discard data, go IDLE.
- Pop: when `inst_valid` && !`stall`, advance rd pointer at the edge.
- Push and pop in the same cycle: both happen, `count` unchanged.
- Redirect has top priority:
  - Clear queue (`count`←0, pointers←0), pop ignored, `fetch_pc`←`redirect_pc`.
  - From IDLE: go IDLE.
  - From REQ without `mem_ack`: go DROP.
  - From REQ with `mem_ack`: ack discarded, no push, go IDLE.
  - From DROP: stay DROP (or go IDLE if `mem_ack`), `fetch_pc` updated.
- Invariant: REQ is only entered with `count` < DEPTH, so a push never overflows.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_addr`=RESET_PC, `fetch_pc`=RESET_PC, `count`=0, `inst_valid`=0, `inst`=NOP, `inst_pc`=0.
- First `mem_req` rises one cycle after `n_rst` deasserts.
- Reset asserted mid-request: all state returns to reset values immediately; no ack is tracked afterwards.
- Ack to `inst_valid` latency: 1 cycle (data pushed on the ack edge, visible next cycle).
- Throughput: with `mem_ack` held high and no stall, one instruction per cycle after the first.
- `inst`, `inst_pc`, `inst_valid`, `count` are derived from registers only, with no combinational path from `mem_*`, `redirect` or `stall`.
- Redirect to new-request latency: 1 cycle from IDLE; from DROP, 1 cycle after the abandoned ack.

## Test plan
- Reset, `mem_ack` tied 1, `mem_rdata`=addr+0x100, `stall`=0 -> `mem_addr` 0,4,8,…; `inst_pc` 0,4,8 with `inst` 0x100,0x104,0x108 on consecutive cycles.
- `stall`=1 throughout, ack always -> exactly 4 pushes; `count`=4, `mem_req` falls to 0; release stall -> pops 0..C in order, fetching resumes at 0x10.
- Redirect to 0x200 while REQ at 0x8 with ack delayed 3 cycles -> state DROP, `mem_addr` stays 0x8, ack data discarded; next request at 0x200, first `inst_pc`=0x200.
- Redirect and `mem_ack` in the same cycle, queue holding 2 entries with `stall`=0 -> `count`=0 next cycle, no push, next `mem_addr`=`redirect_pc`.
- Simultaneous push and pop at `count`=3 -> `count` stays 3, FIFO order preserved across pointer wrap.
- `redirect_pc`=0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000.
- `n_rst` pulsed while `mem_req`=1 -> all outputs at reset values that cycle.
